muxdc_conf_sequencer: RTL and testbench

Configuration sequencer for the multiplexer dataflow controller.
- Accepts a kernel-geometry request (rows, columns) from the layer controller.
- Computes the rows x columns - 1 window size with an iterative adder.
- Drives the four-phase Set_Conf / Set_Conf_Already / Set_Conf_Already_Ok handshake toward the mux controller, with a timeout watchdog.
- Reports done or error upstream; sits between the layer controller and the mux controller.

---
 rtl/muxdc_conf_sequencer_if.sv | 41 ++++
 rtl/muxdc_conf_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_muxdc_conf_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/muxdc_conf_sequencer_if.sv
// Handshake bundle linking the layer controller, the configuration sequencer and the mux controller.
// Defining MUXCS_PERF_CNT_EN adds the MUXCS_Last_Conf_Cycles measurement field.
interface muxdc_conf_sequencer_if #(
  parameter int unsigned BITWIDTH_W_ROWS     = 4,
  parameter int unsigned BITWIDTH_W_COLUMS   = 4,
  parameter int unsigned BITWIDTH_MAX_W_SIZE = 9
);
  logic                           MUXCS_Req;
  logic [BITWIDTH_W_ROWS-1:0]     MUXCS_W_Rows;
  logic [BITWIDTH_W_COLUMS-1:0]   MUXCS_W_Colums;
  logic                           MUXCS_Err_Clr;
  logic                           MUXCS_Muxdc_Set_Conf_Already;
  logic                           MUXCS_Busy;
  logic                           MUXCS_Done;
  logic                           MUXCS_Error;
  logic                           MUXCS_Muxdc_Set_Conf;
  logic                           MUXCS_Muxdc_Set_Conf_Already_Ok;
  logic [BITWIDTH_W_COLUMS-1:0]   MUXCS_Muxdc_W_Colums;
  logic [BITWIDTH_MAX_W_SIZE-1:0] MUXCS_Muxdc_W_ROXCL;
`ifdef MUXCS_PERF_CNT_EN
  logic [15:0]                    MUXCS_Last_Conf_Cycles;
`endif

  modport slave (
    input  MUXCS_Req, MUXCS_W_Rows, MUXCS_W_Colums, MUXCS_Err_Clr, MUXCS_Muxdc_Set_Conf_Already,
    output MUXCS_Busy, MUXCS_Done, MUXCS_Error, MUXCS_Muxdc_Set_Conf,
           MUXCS_Muxdc_Set_Conf_Already_Ok, MUXCS_Muxdc_W_Colums, MUXCS_Muxdc_W_ROXCL
`ifdef MUXCS_PERF_CNT_EN
    , output MUXCS_Last_Conf_Cycles
`endif
  );

  modport master (
    output MUXCS_Req, MUXCS_W_Rows, MUXCS_W_Colums, MUXCS_Err_Clr, MUXCS_Muxdc_Set_Conf_Already,
    input  MUXCS_Busy, MUXCS_Done, MUXCS_Error, MUXCS_Muxdc_Set_Conf,
           MUXCS_Muxdc_Set_Conf_Already_Ok, MUXCS_Muxdc_W_Colums, MUXCS_Muxdc_W_ROXCL
`ifdef MUXCS_PERF_CNT_EN
    , input MUXCS_Last_Conf_Cycles
`endif
  );
endinterface

// File: rtl/muxdc_conf_sequencer.sv
// Configuration sequencer: computes rows x cols - 1 by repeated addition and runs the four-phase
// Set_Conf handshake toward the mux controller with a watchdog. MUXCS_PERF_CNT_EN adds a cycle counter.
module muxdc_conf_sequencer #(
  parameter int unsigned BITWIDTH_W_ROWS     = 4,
  parameter int unsigned BITWIDTH_W_COLUMS   = 4,
  parameter int unsigned BITWIDTH_MAX_W_SIZE = 9,
  parameter int unsigned BITWIDTH_TIMEOUT    = 11,
  parameter int unsigned TIMEOUT_CYCLES      = 1024
) (
  input  logic                  MUXCS_Clk,
  input  logic                  MUXCS_Reset,
  muxdc_conf_sequencer_if.slave bus
);
  localparam int unsigned ACC_W = BITWIDTH_MAX_W_SIZE + 1;
  localparam logic [ACC_W-1:0] ACC_LIMIT = {1'b1, {BITWIDTH_MAX_W_SIZE{1'b0}}};
  localparam logic [BITWIDTH_TIMEOUT-1:0] WD_LAST = BITWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]                     state_q, state_d;
  logic                           req_q;
  logic                           req_rise;
  logic [BITWIDTH_W_ROWS-1:0]     rows_q, rows_d;
  logic [BITWIDTH_W_COLUMS-1:0]   cols_q, cols_d;
  logic [ACC_W-1:0]               acc_q, acc_d, acc_sum;
  logic [BITWIDTH_W_ROWS-1:0]     row_cnt_q, row_cnt_d, row_next;
  logic [BITWIDTH_TIMEOUT-1:0]    wd_q, wd_d;
  logic                           wd_expired;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           error_q, error_d;
  logic                           set_conf_q, set_conf_d;
  logic                           ok_q, ok_d;
  logic [BITWIDTH_MAX_W_SIZE-1:0] roxcl_q, roxcl_d;
  logic [BITWIDTH_W_COLUMS-1:0]   colums_q, colums_d;

  assign req_rise = bus.MUXCS_Req & ~req_q;

  // State and datapath registers
  always_ff @(posedge MUXCS_Clk or negedge MUXCS_Reset) begin
    if (!MUXCS_Reset) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      acc_q      <= '0;
      row_cnt_q  <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      set_conf_q <= 1'b0;
      ok_q       <= 1'b0;
      roxcl_q    <= '0;
      colums_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= bus.MUXCS_Req;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      acc_q      <= acc_d;
      row_cnt_q  <= row_cnt_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      set_conf_q <= set_conf_d;
      ok_q       <= ok_d;
      roxcl_q    <= roxcl_d;
      colums_q   <= colums_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    acc_d      = acc_q;
    row_cnt_d  = row_cnt_q;
    wd_d       = wd_q;
    roxcl_d    = roxcl_q;
    colums_d   = colums_q;
    acc_sum    = acc_q + ACC_W'(cols_q);
    row_next   = row_cnt_q + BITWIDTH_W_ROWS'(1);
    wd_expired = (wd_q == WD_LAST);

    case (state_q)
      S_IDLE: begin
        if (req_rise) begin
          rows_d  = bus.MUXCS_W_Rows;
          cols_d  = bus.MUXCS_W_Colums;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rows_q == '0 || cols_q == '0) begin
          state_d = S_ERR;
        end else begin
          acc_d     = '0;
          row_cnt_d = '0;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        acc_d     = acc_sum;
        row_cnt_d = row_next;
        if (acc_sum > ACC_LIMIT)       state_d = S_ERR;
        else if (row_next == rows_q)   state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // acc_q never exceeds ACC_LIMIT here, so acc - 1 always fits the result width
        roxcl_d  = BITWIDTH_MAX_W_SIZE'(acc_q - ACC_W'(1));
        colums_d = cols_q;
        wd_d     = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.MUXCS_Muxdc_Set_Conf_Already) begin
          wd_d    = '0;
          state_d = S_ACK;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + BITWIDTH_TIMEOUT'(1);
        end
      end
      S_ACK: begin
        if (!bus.MUXCS_Muxdc_Set_Conf_Already) state_d = S_DONE;
        else if (wd_expired)                   state_d = S_ERR;
        else                                   wd_d = wd_q + BITWIDTH_TIMEOUT'(1);
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (bus.MUXCS_Err_Clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake lines follow the state being entered; status lines follow the current state
    set_conf_d = (state_d == S_WAIT);
    ok_d       = (state_d == S_ACK);
    busy_d     = (state_q != S_IDLE) && (state_q != S_ERR);
    done_d     = (state_q == S_DONE);
    error_d    = (state_q == S_ERR) && !bus.MUXCS_Err_Clr;
  end

  assign bus.MUXCS_Busy                      = busy_q;
  assign bus.MUXCS_Done                      = done_q;
  assign bus.MUXCS_Error                     = error_q;
  assign bus.MUXCS_Muxdc_Set_Conf            = set_conf_q;
  assign bus.MUXCS_Muxdc_Set_Conf_Already_Ok = ok_q;
  assign bus.MUXCS_Muxdc_W_ROXCL             = roxcl_q;
  assign bus.MUXCS_Muxdc_W_Colums            = colums_q;

`ifdef MUXCS_PERF_CNT_EN
  logic [15:0] perf_cnt_q;
  logic [15:0] last_cycles_q;

  // Accept-to-DONE cycle count, published when Done rises
  always_ff @(posedge MUXCS_Clk or negedge MUXCS_Reset) begin
    if (!MUXCS_Reset) begin
      perf_cnt_q    <= '0;
      last_cycles_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        if (req_rise) perf_cnt_q <= '0;
      end else if (state_q != S_ERR && state_q != S_DONE && perf_cnt_q != 16'hFFFF) begin
        perf_cnt_q <= perf_cnt_q + 16'd1;
      end
      if (state_q == S_DONE) last_cycles_q <= perf_cnt_q;
    end
  end

  assign bus.MUXCS_Last_Conf_Cycles = last_cycles_q;
`endif

endmodule

// File: tb/tb_muxdc_conf_sequencer.sv
// Randomized self-checking bench for muxdc_conf_sequencer; expected timing is derived per request
// from the geometry and the handshake delays the bench chooses.
`timescale 1ns/1ps
module tb_muxdc_conf_sequencer;
  localparam int TO = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   old_roxcl = 0;
  int   old_colums = 0;
  int   old_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muxdc_conf_sequencer_if #(.BITWIDTH_W_ROWS(4), .BITWIDTH_W_COLUMS(4), .BITWIDTH_MAX_W_SIZE(9)) bus ();
  muxdc_conf_sequencer_if #(.BITWIDTH_W_ROWS(4), .BITWIDTH_W_COLUMS(4), .BITWIDTH_MAX_W_SIZE(7)) bus7 ();

  muxdc_conf_sequencer #(.BITWIDTH_MAX_W_SIZE(9)) dut (
    .MUXCS_Clk(clk), .MUXCS_Reset(rst_n), .bus(bus)
  );
  muxdc_conf_sequencer #(.BITWIDTH_MAX_W_SIZE(7)) dut7 (
    .MUXCS_Clk(clk), .MUXCS_Reset(rst_n), .bus(bus7)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Error recovery: a Req edge in ERR is ignored, and a Req edge together with Err_Clr is discarded
  task automatic clear_err();
    bus.MUXCS_Req = 1'b0; step();
    check("err_sticky", 32'(bus.MUXCS_Error), 32'd1);
    bus.MUXCS_Req = 1'b1; step();
    check("err_req_ignored", 32'(bus.MUXCS_Busy), 32'd0);
    bus.MUXCS_Req = 1'b0; step();
    bus.MUXCS_Req = 1'b1; bus.MUXCS_Err_Clr = 1'b1; step();
    check("err_clr", 32'(bus.MUXCS_Error), 32'd0);
    bus.MUXCS_Err_Clr = 1'b0;
    repeat (2) begin
      step();
      check("clr_req_discard", 32'(bus.MUXCS_Busy), 32'd0);
    end
    bus.MUXCS_Req = 1'b0;
    step();
  endtask

  // One request: d1 = cycles after Set_Conf before Already rises (>= TO: never),
  // d2 = cycles Already is kept high (>= TO: never dropped)
  task automatic run_conf(input int r, input int c, input int d1, input int d2, input bit hold);
    int k, s, a, d, e, last, sc_end, ok_end;
    bus.MUXCS_Req = 1'b0; step();
    bus.MUXCS_W_Rows = 4'(r); bus.MUXCS_W_Colums = 4'(c); bus.MUXCS_Req = 1'b1;
    step(); k = cyc;
    if (!hold) bus.MUXCS_Req = 1'b0;
    bus.MUXCS_W_Rows = 4'($urandom); bus.MUXCS_W_Colums = 4'($urandom);

    if (r == 0 || c == 0) begin
      step();
      check("geom_busy", 32'(bus.MUXCS_Busy), 32'd1);
      step();
      check("geom_err", 32'(bus.MUXCS_Error), 32'd1);
      check("geom_busy_off", 32'(bus.MUXCS_Busy), 32'd0);
      check("geom_no_setconf", 32'(bus.MUXCS_Muxdc_Set_Conf), 32'd0);
      check("geom_roxcl_hold", 32'(bus.MUXCS_Muxdc_W_ROXCL), 32'(old_roxcl));
      clear_err();
      return;
    end

    s = k + 2 + r;
    a = (d1 >= TO) ? -1 : s + d1 + 1;
    if (a < 0)          e = s + TO;
    else if (d2 >= TO)  e = a + TO;
    else                e = -1;
    d      = (e < 0) ? a + d2 : -1;
    last   = (e >= 0) ? e + 1 : d + 2;
    sc_end = (a >= 0) ? a : e;
    ok_end = (d >= 0) ? d : e;

    while (cyc <= last) begin
      bus.MUXCS_Muxdc_Set_Conf_Already = (a >= 0) && (cyc + 1 >= a) && (d2 >= TO || cyc + 1 < a + d2);
      step();
      check("set_conf", 32'(bus.MUXCS_Muxdc_Set_Conf), 32'(cyc >= s && cyc < sc_end));
      check("already_ok", 32'(bus.MUXCS_Muxdc_Set_Conf_Already_Ok), 32'(a >= 0 && cyc >= a && cyc < ok_end));
      check("busy", 32'(bus.MUXCS_Busy), 32'(cyc >= k + 1 && cyc < last));
      check("done", 32'(bus.MUXCS_Done), 32'(d >= 0 && cyc == d + 1));
      check("error", 32'(bus.MUXCS_Error), 32'(e >= 0 && cyc >= e + 1));
      check("roxcl", 32'(bus.MUXCS_Muxdc_W_ROXCL), 32'((cyc >= s) ? r * c - 1 : old_roxcl));
      check("colums", 32'(bus.MUXCS_Muxdc_W_Colums), 32'((cyc >= s) ? c : old_colums));
`ifdef MUXCS_PERF_CNT_EN
      check("last_cycles", 32'(bus.MUXCS_Last_Conf_Cycles), 32'((d >= 0 && cyc >= d + 1) ? d - k : old_last));
`endif
    end
    bus.MUXCS_Muxdc_Set_Conf_Already = 1'b0;
    old_roxcl  = r * c - 1;
    old_colums = c;
    if (d >= 0) old_last = d - k;

    if (hold) begin
      repeat (3) begin
        step();
        check("hold_no_retrigger", 32'(bus.MUXCS_Busy), 32'd0);
      end
    end
    if (e >= 0) clear_err();
    bus.MUXCS_Req = 1'b0;
  endtask

  initial begin
    int k7;
    int seen;
    bus.MUXCS_Req = 1'b0; bus.MUXCS_W_Rows = '0; bus.MUXCS_W_Colums = '0;
    bus.MUXCS_Err_Clr = 1'b0; bus.MUXCS_Muxdc_Set_Conf_Already = 1'b0;
    bus7.MUXCS_Req = 1'b0; bus7.MUXCS_W_Rows = '0; bus7.MUXCS_W_Colums = '0;
    bus7.MUXCS_Err_Clr = 1'b0; bus7.MUXCS_Muxdc_Set_Conf_Already = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(bus.MUXCS_Busy), 32'd0);
    check("rst_done", 32'(bus.MUXCS_Done), 32'd0);
    check("rst_error", 32'(bus.MUXCS_Error), 32'd0);
    check("rst_set_conf", 32'(bus.MUXCS_Muxdc_Set_Conf), 32'd0);
    check("rst_ok", 32'(bus.MUXCS_Muxdc_Set_Conf_Already_Ok), 32'd0);
    check("rst_roxcl", 32'(bus.MUXCS_Muxdc_W_ROXCL), 32'd0);
    check("rst_colums", 32'(bus.MUXCS_Muxdc_W_Colums), 32'd0);
    rst_n = 1'b1;
    step();

    // 15 x 15 overflows a 7-bit result on the 9th accumulation
    bus7.MUXCS_W_Rows = 4'd15; bus7.MUXCS_W_Colums = 4'd15; bus7.MUXCS_Req = 1'b1;
    step(); k7 = cyc; bus7.MUXCS_Req = 1'b0;
    repeat (12) begin
      step();
      check("ovf_set_conf", 32'(bus7.MUXCS_Muxdc_Set_Conf), 32'd0);
      check("ovf_error", 32'(bus7.MUXCS_Error), 32'(cyc >= k7 + 11));
    end
    bus7.MUXCS_Err_Clr = 1'b1; step();
    check("ovf_clr", 32'(bus7.MUXCS_Error), 32'd0);
    bus7.MUXCS_Err_Clr = 1'b0;

    run_conf(3, 3, 3, 2, 1'b0);
    run_conf(0, 5, 0, 1, 1'b0);
    run_conf(15, 15, 2, 3, 1'b0);
    run_conf(4, 2, TO, 1, 1'b0);
    run_conf(2, 2, 1, TO, 1'b0);
    run_conf(1, 1, 0, 1, 1'b0);

    // Reset while in ACK aborts without Done
    bus.MUXCS_W_Rows = 4'd3; bus.MUXCS_W_Colums = 4'd2; bus.MUXCS_Req = 1'b1;
    step(); bus.MUXCS_Req = 1'b0;
    bus.MUXCS_Muxdc_Set_Conf_Already = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      step();
      if (bus.MUXCS_Muxdc_Set_Conf_Already_Ok === 1'b1) seen = 1;
    end
    check("ack_reached", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ok", 32'(bus.MUXCS_Muxdc_Set_Conf_Already_Ok), 32'd0);
    check("arst_busy", 32'(bus.MUXCS_Busy), 32'd0);
    check("arst_set_conf", 32'(bus.MUXCS_Muxdc_Set_Conf), 32'd0);
    check("arst_roxcl", 32'(bus.MUXCS_Muxdc_W_ROXCL), 32'd0);
    bus.MUXCS_Muxdc_Set_Conf_Already = 1'b0;
    step();
    check("arst_no_done", 32'(bus.MUXCS_Done), 32'd0);
    rst_n = 1'b1;
    old_roxcl = 0; old_colums = 0; old_last = 0;
    step();
    run_conf(2, 4, 1, 2, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int r, c;
      r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      run_conf(r, c, int'($urandom_range(0, 7)), int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a wait never resolves
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
